// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if
// Groups the match-controller request/status signals into one bundle.
//   Requests (into the controller): start, p1_point, p2_point
//   Status (out of the controller): tick, state, start_o, reset_game, serve,
//                                   server, serve_angle, sc1, sc2, winner
//   slave  modport : the match controller itself
//   master modport : whatever drives requests and consumes status
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 3,
  parameter int ANGLE_W = 7
);
  logic               start;
  logic               p1_point;
  logic               p2_point;
  logic               tick;
  logic [2:0]         state;
  logic               start_o;
  logic               reset_game;
  logic               serve;
  logic               server;
  logic [ANGLE_W-1:0] serve_angle;
  logic [SCORE_W-1:0] sc1;
  logic [SCORE_W-1:0] sc2;
  logic [1:0]         winner;

  modport slave (
    input  start, p1_point, p2_point,
    output tick, state, start_o, reset_game, serve, server,
           serve_angle, sc1, sc2, winner
  );

  modport master (
    output start, p1_point, p2_point,
    input  tick, state, start_o, reset_game, serve, server,
           serve_angle, sc1, sc2, winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// Match sequencing for a two-player pong game: opening screen, serve delay,
// rally, point scoring, win detection and match restart.
// Ports:
//   sys_clock : single clock, all state changes on its rising edge
//   reset     : asynchronous, active-low
//   bus       : pong_match_ctrl_if.slave
//               start/p1_point/p2_point in; tick, state, start_o,
//               reset_game, serve, server, serve_angle, sc1, sc2, winner out
// tick, serve and reset_game are single-cycle combinational pulses decoded
// from registered state; everything else is registered.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int TICK_DIV    = 100,
  parameter int SERVE_TICKS = 4,
  parameter int ANGLE_MAX   = 90,
  parameter int ANGLE_W     = 7
) (
  input  logic              sys_clock,
  input  logic              reset,
  pong_match_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    WIN   = 3'd4
  } state_t;

  localparam int TICK_CW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SERVE_CW = $clog2(SERVE_TICKS + 1);

  localparam logic [TICK_CW-1:0]  TICK_LAST  = TICK_CW'(TICK_DIV - 1);
  localparam logic [ANGLE_W-1:0]  ANGLE_LAST = ANGLE_W'(ANGLE_MAX - 1);
  localparam logic [SERVE_CW-1:0] SERVE_LAST = SERVE_CW'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0]  WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t              state_q;
  state_t              state_d;
  logic [TICK_CW-1:0]  tick_cnt;
  logic [ANGLE_W-1:0]  angle_cnt;
  logic [SERVE_CW-1:0] serve_cnt;
  logic [SCORE_W-1:0]  sc1_q;
  logic [SCORE_W-1:0]  sc2_q;
  logic [1:0]          winner_q;
  logic                server_q;
  logic [ANGLE_W-1:0]  serve_angle_q;
  logic                start_o_q;

  logic tick_w;
  logic new_match;
  logic serve_fire;
  logic serve_count;
  logic serve_clear;
  logic score_p1;
  logic score_p2;
  logic set_win_p1;
  logic set_win_p2;

  // During reset tick_cnt sits at 0 and TICK_LAST is at least 1, so tick
  // stays low without extra gating.
  assign tick_w = (tick_cnt == TICK_LAST);

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick_w) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_CW'(1);
    end
  end

  // Free-running sweep; the value at the serve edge becomes the serve angle.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      angle_cnt <= '0;
    end else if (angle_cnt == ANGLE_LAST) begin
      angle_cnt <= '0;
    end else begin
      angle_cnt <= angle_cnt + ANGLE_W'(1);
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    new_match   = 1'b0;
    serve_fire  = 1'b0;
    serve_count = 1'b0;
    serve_clear = 1'b0;
    score_p1    = 1'b0;
    score_p2    = 1'b0;
    set_win_p1  = 1'b0;
    set_win_p2  = 1'b0;
    case (state_q)
      IDLE, WIN: begin
        if (bus.start) begin
          state_d     = SERVE;
          new_match   = 1'b1;
          serve_clear = 1'b1;
        end
      end
      SERVE: begin
        if (tick_w) begin
          if (serve_cnt == SERVE_LAST) begin
            serve_fire = 1'b1;
            state_d    = PLAY;
          end else begin
            serve_count = 1'b1;
          end
        end
      end
      PLAY: begin
        // Simultaneous point pulses are a let: re-serve, nobody scores.
        case ({bus.p1_point, bus.p2_point})
          2'b10: begin
            score_p1 = 1'b1;
            state_d  = POINT;
          end
          2'b01: begin
            score_p2 = 1'b1;
            state_d  = POINT;
          end
          2'b11: begin
            state_d     = SERVE;
            serve_clear = 1'b1;
          end
          default: ;
        endcase
      end
      POINT: begin
        if (sc1_q == WIN_VAL) begin
          set_win_p1 = 1'b1;
          state_d    = WIN;
        end else if (sc2_q == WIN_VAL) begin
          set_win_p2 = 1'b1;
          state_d    = WIN;
        end else begin
          state_d     = SERVE;
          serve_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      serve_cnt <= '0;
    end else if (serve_clear) begin
      serve_cnt <= '0;
    end else if (serve_count) begin
      serve_cnt <= serve_cnt + SERVE_CW'(1);
    end
  end

  // Scores saturate at WIN_SCORE as a safeguard; POINT normally ends the
  // match before a further increment could happen.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      sc1_q    <= '0;
      sc2_q    <= '0;
      winner_q <= 2'b00;
    end else if (new_match) begin
      sc1_q    <= '0;
      sc2_q    <= '0;
      winner_q <= 2'b00;
    end else begin
      if (score_p1 && (sc1_q != WIN_VAL)) begin
        sc1_q <= sc1_q + SCORE_W'(1);
      end
      if (score_p2 && (sc2_q != WIN_VAL)) begin
        sc2_q <= sc2_q + SCORE_W'(1);
      end
      if (set_win_p1) begin
        winner_q <= 2'b01;
      end else if (set_win_p2) begin
        winner_q <= 2'b10;
      end
    end
  end

  // The player who lost the point serves next. A rematch from WIN keeps
  // the last server; a fresh match from IDLE starts with player 1.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      server_q <= 1'b0;
    end else if (new_match && (state_q == IDLE)) begin
      server_q <= 1'b0;
    end else if (score_p1) begin
      server_q <= 1'b1;
    end else if (score_p2) begin
      server_q <= 1'b0;
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      serve_angle_q <= '0;
    end else if (serve_fire) begin
      serve_angle_q <= angle_cnt;
    end
  end

  // Registered from the next state so it lines up with state_q.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      start_o_q <= 1'b1;
    end else begin
      start_o_q <= (state_d == IDLE);
    end
  end

  // start is a free input, so reset_game needs explicit gating while reset
  // is held; the other pulses are already quiet in the reset state.
  assign bus.tick        = tick_w;
  assign bus.state       = state_q;
  assign bus.start_o     = start_o_q;
  assign bus.reset_game  = new_match & reset;
  assign bus.serve       = serve_fire;
  assign bus.server      = server_q;
  assign bus.serve_angle = serve_angle_q;
  assign bus.sc1         = sc1_q;
  assign bus.sc2         = sc2_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl
// Directed bench for pong_match_ctrl with a small behavioural match model.
// The model is compared against every output on each falling edge; literal
// checks in the stimulus pin the model to hand-computed values.
module tb_pong_match_ctrl;

  localparam int WIN_SCORE   = 3;
  localparam int SCORE_W     = 2;
  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int ANGLE_MAX   = 5;
  localparam int ANGLE_W     = 3;

  logic sys_clock = 1'b0;
  logic reset     = 1'b0;

  pong_match_ctrl_if #(.SCORE_W(SCORE_W), .ANGLE_W(ANGLE_W)) bus ();

  pong_match_ctrl #(
    .WIN_SCORE  (WIN_SCORE),
    .SCORE_W    (SCORE_W),
    .TICK_DIV   (TICK_DIV),
    .SERVE_TICKS(SERVE_TICKS),
    .ANGLE_MAX  (ANGLE_MAX),
    .ANGLE_W    (ANGLE_W)
  ) dut (
    .sys_clock(sys_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 sys_clock = ~sys_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string name, input logic [31:0] actual,
                           input int expected);
    n_checks++;
    if (actual !== 32'(expected)) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Match model: phase numbers follow the published state encoding.
  int m_state, m_div, m_ang, m_stk, m_sc1, m_sc2, m_win, m_server, m_sang;
  int m_start_o;

  task automatic model_reset();
    m_state   = 0;
    m_div     = 0;
    m_ang     = 0;
    m_stk     = 0;
    m_sc1     = 0;
    m_sc2     = 0;
    m_win     = 0;
    m_server  = 0;
    m_sang    = 0;
    m_start_o = 1;
  endtask

  task automatic model_step(input bit t, input bit st, input bit p1,
                            input bit p2);
    int ang_now;
    ang_now = m_ang;
    m_div   = (m_div + 1) % TICK_DIV;
    m_ang   = (m_ang + 1) % ANGLE_MAX;
    case (m_state)
      0, 4: begin
        if (st) begin
          if (m_state == 0) m_server = 0;
          m_state = 1;
          m_sc1   = 0;
          m_sc2   = 0;
          m_win   = 0;
          m_stk   = 0;
        end
      end
      1: begin
        if (t) begin
          m_stk++;
          if (m_stk == SERVE_TICKS) begin
            m_state = 2;
            m_sang  = ang_now;
          end
        end
      end
      2: begin
        if (p1 && p2) begin
          m_state = 1;
          m_stk   = 0;
        end else if (p1) begin
          if (m_sc1 < WIN_SCORE) m_sc1++;
          m_server = 1;
          m_state  = 3;
        end else if (p2) begin
          if (m_sc2 < WIN_SCORE) m_sc2++;
          m_server = 0;
          m_state  = 3;
        end
      end
      3: begin
        if (m_sc1 == WIN_SCORE) begin
          m_win   = 1;
          m_state = 4;
        end else if (m_sc2 == WIN_SCORE) begin
          m_win   = 2;
          m_state = 4;
        end else begin
          m_state = 1;
          m_stk   = 0;
        end
      end
      default: m_state = 0;
    endcase
    m_start_o = (m_state == 0) ? 1 : 0;
  endtask

  initial model_reset();

  always @(negedge sys_clock) begin : compare
    bit e_tick, e_rg, e_serve;
    if (!reset) model_reset();
    e_tick  = reset && (m_div == TICK_DIV - 1);
    e_rg    = reset && (m_state == 0 || m_state == 4) && (bus.start === 1'b1);
    e_serve = reset && (m_state == 1) && e_tick && (m_stk + 1 == SERVE_TICKS);
    check_val("cyc_tick",        bus.tick,        int'(e_tick));
    check_val("cyc_reset_game",  bus.reset_game,  int'(e_rg));
    check_val("cyc_serve",       bus.serve,       int'(e_serve));
    check_val("cyc_state",       bus.state,       m_state);
    check_val("cyc_start_o",     bus.start_o,     m_start_o);
    check_val("cyc_server",      bus.server,      m_server);
    check_val("cyc_serve_angle", bus.serve_angle, m_sang);
    check_val("cyc_sc1",         bus.sc1,         m_sc1);
    check_val("cyc_sc2",         bus.sc2,         m_sc2);
    check_val("cyc_winner",      bus.winner,      m_win);
    if (reset) model_step(e_tick, bus.start, bus.p1_point, bus.p2_point);
  end

  task automatic step();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic apply_stimulus(input bit st, input bit p1, input bit p2);
    bus.start    = st;
    bus.p1_point = p1;
    bus.p2_point = p2;
  endtask

  // Returns while serve is high, n = cycles waited; expiry is a failure.
  task automatic wait_serve(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.serve !== 1'b1 && n < 100);
    check_val("serve_timeout", int'(bus.serve === 1'b1), 1);
  endtask

  task automatic check_output(input string tag, input int st, input int s1,
                              input int s2, input int wn, input int srv);
    check_val({tag, "_state"},  bus.state,  st);
    check_val({tag, "_sc1"},    bus.sc1,    s1);
    check_val({tag, "_sc2"},    bus.sc2,    s2);
    check_val({tag, "_winner"}, bus.winner, wn);
    check_val({tag, "_server"}, bus.server, srv);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    int ang_exp [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
    int ticks;
    int n;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    reset = 1'b1;

    // Idle: tick every 4th cycle, angle sweeps 0..4, no match activity.
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.tick === 1'b1) ticks++;
      check_val("idle_serve", bus.serve, 0);
      if (k < 12) begin
        check_val("angle_seq", dut.angle_cnt, ang_exp[k]);
        check_val("angle_range", int'(dut.angle_cnt < 3'd5), 1);
      end
    end
    check_val("idle_tick_count", ticks, 5);
    check_val("idle_state", bus.state, 0);
    check_val("idle_start_o", bus.start_o, 1);

    // Start: reset_game in the start cycle, serve after the 2nd tick.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    #1;
    check_val("start_reset_game", bus.reset_game, 1);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_val("serve_state", bus.state, 1);
    check_val("serve_start_o", bus.start_o, 0);
    wait_serve(n);
    check_val("serve_wait", n, 6);
    step();
    check_val("play_state", bus.state, 2);
    check_val("serve_angle_lit", bus.serve_angle, 2);

    // Player 2 scores, then a let.
    apply_stimulus(1'b0, 1'b0, 1'b1);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("p2_point", 3, 0, 1, 0, 0);
    step();
    check_val("p2_reserve_state", bus.state, 1);
    wait_serve(n);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b1);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("let", 1, 0, 1, 0, 0);

    // Point pulse during SERVE is ignored.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_val("serve_ignore_sc1", bus.sc1, 0);
    wait_serve(n);
    step();

    // Player 1 takes three points and the match.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      step();
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("p1_point", 3, i + 1, 1, 0, 1);
      step();
      if (i < 2) begin
        check_val("p1_reserve_state", bus.state, 1);
        wait_serve(n);
        step();
      end
    end
    check_output("win", 4, 3, 1, 1, 1);

    // Points ignored in WIN.
    apply_stimulus(1'b0, 1'b0, 1'b1);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    step();
    check_output("win_hold", 4, 3, 1, 1, 1);

    // Rematch keeps the server.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    #1;
    check_val("rematch_reset_game", bus.reset_game, 1);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("rematch", 1, 0, 0, 0, 1);

    // Reset mid-SERVE with the tick divider at 2.
    n = 0;
    while (!(m_div == 2 && bus.state == 3'd1) && n < 20) begin
      step();
      n++;
    end
    check_val("abort_setup", int'(m_div == 2 && bus.state == 3'd1), 1);
    reset = 1'b0;
    #1;
    check_output("abort", 0, 0, 0, 0, 0);
    check_val("abort_start_o", bus.start_o, 1);
    check_val("abort_serve_angle", bus.serve_angle, 0);
    check_val("abort_tick", bus.tick, 0);
    check_val("abort_serve", bus.serve, 0);
    check_val("abort_reset_game", bus.reset_game, 0);
    repeat (3) begin
      step();
      check_val("abort_hold_serve", bus.serve, 0);
    end
    reset = 1'b1;
    repeat (8) step();
    check_val("post_abort_state", bus.state, 0);
    check_val("post_abort_start_o", bus.start_o, 1);

    @(negedge sys_clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win a match; legal range 1 to 2^SCORE_W-1.
REQ-002 Parameter SCORE_W, default 3: width of each score counter.
REQ-003 Parameter TICK_DIV, default 100: sys_clock cycles per game tick; minimum 2.
REQ-004 Parameter SERVE_TICKS, default 4: game ticks spent in SERVE before the ball is released; minimum 1.
REQ-005 Parameter ANGLE_MAX, default 90: serve-angle sweep modulus.
REQ-006 Parameter ANGLE_W, default 7: angle width; 2^ANGLE_W SHALL be at least ANGLE_MAX.
REQ-007 sys_clock  in  1  the single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset; state clears while low.
REQ-009 start  in  1  level start request, sampled on every sys_clock.
REQ-010 p1_point  in  1  one-cycle pulse from ball logic: player 1 scored.
REQ-011 p2_point  in  1  one-cycle pulse from ball logic: player 2 scored.
REQ-012 tick  out  1  one-cycle game-rate enable.
REQ-013 state  out  3  encoded FSM state: IDLE=0, SERVE=1, PLAY=2, POINT=3, WIN=4.
REQ-014 start_o  out  1  high in IDLE only: opening screen select.
REQ-015 reset_game  out  1  one-cycle pulse at the start of each new match.
REQ-016 serve  out  1  one-cycle pulse when the ball is released.
REQ-017 server  out  1  serving player: 0 = player 1, 1 = player 2.
REQ-018 serve_angle  out  ANGLE_W  angle latched when serve pulses.
REQ-019 sc1, sc2  out  SCORE_W each  player scores.
REQ-020 winner  out  2  00 none, 01 player 1, 10 player 2.

Function
REQ-021 The tick divider SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high in the cycle the count equals TICK_DIV-1; it SHALL run in every state.
REQ-022 The angle counter SHALL increment every sys_clock, wrapping from ANGLE_MAX-1 to 0; it SHALL be free-running in every state.
REQ-023 IDLE: on start=1, the FSM SHALL go to SERVE, pulse reset_game in the same cycle, and clear sc1, sc2 and winner to 0.
REQ-024 SERVE: the FSM SHALL count SERVE_TICKS ticks; on the tick completing the count it SHALL pulse serve, latch the current angle into serve_angle, and enter PLAY.
REQ-025 The serve-tick counter SHALL clear on every entry to SERVE.
REQ-026 PLAY, p1_point only: sc1 SHALL increment by 1, server SHALL become 1 (the loser serves), and the FSM SHALL enter POINT.
REQ-027 PLAY, p2_point only: sc2 SHALL increment by 1, server SHALL become 0, and the FSM SHALL enter POINT.
REQ-028 PLAY, both pulses in the same cycle: this is a let; scores and server SHALL remain unchanged and the FSM SHALL go to SERVE.
REQ-029 p1_point and p2_point SHALL be ignored in every state except PLAY.
REQ-030 POINT, one cycle: if sc1 equals WIN_SCORE, winner SHALL become 01 and the FSM SHALL enter WIN; else if sc2 equals WIN_SCORE, winner SHALL become 10 and the FSM SHALL enter WIN; otherwise the FSM SHALL enter SERVE.
REQ-031 WIN: scores and winner SHALL hold; on start=1, the FSM SHALL behave exactly as REQ-023, except that server is not reset.
REQ-032 start SHALL be ignored in SERVE, PLAY and POINT.
REQ-033 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-034 serve, reset_game and tick SHALL each be high for exactly one cycle per event.
REQ-035 start_o SHALL be a registered output equal to 1 exactly when state is IDLE.

Reset
REQ-036 While reset=0, the block SHALL set state=IDLE, start_o=1, sc1=sc2=0, winner=00, server=0, serve_angle=0, and clear both the tick and angle counters.
REQ-037 While reset=0, the block SHALL hold tick, serve and reset_game at 0.
REQ-038 Reset asserted mid-match SHALL abort the match immediately with no further pulses; after release the block SHALL wait in IDLE for start.

Verification
REQ-039 Parameters TICK_DIV=4, SERVE_TICKS=2; release reset, hold start=0 for 20 cycles -> tick every 4th cycle, state=0, start_o=1, no serve pulse.
REQ-040 Pulse start=1 for 1 cycle -> reset_game pulses that cycle, state=1; serve pulses on the 2nd subsequent tick; serve_angle equals the angle count at that cycle; state=2.
REQ-041 In PLAY, pulse p2_point -> sc2=1, server=0, state passes 3 then 1; on a later rally pulse p1_point and p2_point together -> scores unchanged, state=1.
REQ-042 WIN_SCORE=3: give player 1 three points -> winner=01, state=4; further p2_point pulses ignored; start -> sc1=sc2=0, winner=00, reset_game pulse.
REQ-043 Drive reset low during SERVE with the tick count at 2 -> immediate IDLE with all REQ-036 values, no serve pulse.
REQ-044 ANGLE_MAX=5: observe the angle sequence over 12 cycles -> 0,1,2,3,4,0,... with no value at or above 5.
